// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if -- bundle of the fetch controller's request and control signals.
//
// Purpose : groups the fetch controller's inputs and outputs so the pipeline
//           (master) and the controller (slave) connect through one port.
//           The clock and reset are not part of the bundle.
//
// Signals (direction as seen by the slave / fetch_ctrl):
//   stall_req      in   1   load-use hazard: hold PC and IF/ID this cycle
//   br_taken       in   1   resolved taken branch, br_target valid
//   br_target      in  64   branch target address
//   halt_req       in   1   request to stop fetching
//   resume         in   1   leave HALT
//   pc_write       out  1   PC register enable
//   pc_src         out  1   PC mux select: 0 = PC+4, 1 = pc_br
//   pc_br          out 64   registered redirect target
//   ifid_write     out  1   IF/ID register enable
//   ifid_flush     out  1   IF/ID bubble insert
//   fetch_state    out  2   BOOT=0, RUN=1, REDIRECT=2, HALT=3
//   stall_timeout  out  1   sticky stall watchdog flag
//   perf_*         out 32   performance counters (fetch, stall, redirect)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
   logic        stall_req;
   logic        br_taken;
   logic [63:0] br_target;
   logic        halt_req;
   logic        resume;
   logic        pc_write;
   logic        pc_src;
   logic [63:0] pc_br;
   logic        ifid_write;
   logic        ifid_flush;
   logic [1:0]  fetch_state;
   logic        stall_timeout;
   logic [31:0] perf_fetch;
   logic [31:0] perf_stall;
   logic [31:0] perf_redirect;

   // Pipeline side: raises requests, consumes the control outputs.
   modport master (
      output stall_req, br_taken, br_target, halt_req, resume,
      input  pc_write, pc_src, pc_br, ifid_write, ifid_flush,
      input  fetch_state, stall_timeout, perf_fetch, perf_stall, perf_redirect
   );

   // Controller side.
   modport slave (
      input  stall_req, br_taken, br_target, halt_req, resume,
      output pc_write, pc_src, pc_br, ifid_write, ifid_flush,
      output fetch_state, stall_timeout, perf_fetch, perf_stall, perf_redirect
   );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch controller.
//
// Purpose : sequences the PC / IF/ID enables through BOOT, RUN, REDIRECT and
//           HALT. Event priority is br_taken > halt_req > stall_req. A 16-bit
//           stall counter saturating at STALL_LIMIT drives a sticky watchdog.
//
// Parameters:
//   BOOT_CYCLES  (1..15)     cycles the PC is held after reset release
//   STALL_LIMIT  (1..65535)  consecutive stalled RUN cycles that set stall_timeout
//
// Ports:
//   clk     in  rising-edge clock
//   rst     in  asynchronous, active-low reset
//   io_bus  fetch_ctrl_if.slave (requests in, PC/IF-ID control and status out)
//
// Configuration:
//   FETCH_CTRL_PERF_CNT_EN  defined: builds the saturating 32-bit perf counters
//                           (fetch = cycles with pc_write, stall = stalled RUN
//                           cycles, redirect = REDIRECT cycles).
//                           undefined: perf outputs tied to zero.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int unsigned BOOT_CYCLES = 2,
   parameter int unsigned STALL_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   fetch_ctrl_if.slave io_bus
);

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_REDIRECT = 2'd2,
      ST_HALT     = 2'd3
   } state_t;

   localparam logic [3:0]  BOOT_LAST = 4'(BOOT_CYCLES - 1);
   localparam logic [15:0] STALL_MAX = 16'(STALL_LIMIT);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_boot_cnt;
   logic [63:0] r_pc_br;
   logic [15:0] r_stall_cnt;
   logic [15:0] w_stall_cnt_nxt;
   logic        r_stall_timeout;

   logic        w_pc_write;
   logic        w_pc_src;
   logic        w_ifid_write;
   logic        w_ifid_flush;
   logic        w_br_accept;
   logic        w_run_stall;

   // A branch is only taken on board in RUN or REDIRECT; BOOT and HALT drop it.
   assign w_br_accept = io_bus.br_taken &&
                        ((r_state == ST_RUN) || (r_state == ST_REDIRECT));
   assign w_run_stall = (r_state == ST_RUN) && io_bus.stall_req;

   // Counts consecutive stalled RUN cycles; any other cycle restarts it.
   always_comb begin
      w_stall_cnt_nxt = '0;
      if (w_run_stall) begin
         w_stall_cnt_nxt = (r_stall_cnt == STALL_MAX) ? r_stall_cnt
                                                      : r_stall_cnt + 16'd1;
      end
   end

   // Next-state and control outputs.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      w_state_nxt  = r_state;
      w_pc_write   = 1'b0;
      w_pc_src     = 1'b0;
      w_ifid_write = 1'b0;
      w_ifid_flush = 1'b0;

      unique case (r_state)
         ST_BOOT: begin
            w_ifid_flush = 1'b1;
            if (r_boot_cnt == BOOT_LAST) w_state_nxt = ST_RUN;
         end

         ST_RUN: begin
            // Stall gates the enables in the same cycle, even alongside a branch.
            w_pc_write   = !io_bus.stall_req;
            w_ifid_write = !io_bus.stall_req;
            if (io_bus.br_taken)      w_state_nxt = ST_REDIRECT;
            else if (io_bus.halt_req) w_state_nxt = ST_HALT;
         end

         ST_REDIRECT: begin
            // The redirect always commits; stall_req has no say here.
            w_pc_src     = 1'b1;
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = 1'b1;
            if (io_bus.br_taken)      w_state_nxt = ST_REDIRECT;
            else if (io_bus.halt_req) w_state_nxt = ST_HALT;
            else                      w_state_nxt = ST_RUN;
         end

         ST_HALT: begin
            // A still-asserted halt_req wins over resume.
            if (io_bus.resume && !io_bus.halt_req) w_state_nxt = ST_RUN;
         end

         default: w_state_nxt = ST_BOOT;
      endcase
   end

   // NOTE: the reset branch sits in the sensitivity list (negedge rst) so the
   // controller drops back to BOOT immediately, without waiting for a clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state         <= ST_BOOT;
         r_boot_cnt      <= '0;
         r_pc_br         <= '0;
         r_stall_cnt     <= '0;
         r_stall_timeout <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values, independent of statement order.
         r_state     <= w_state_nxt;
         r_stall_cnt <= w_stall_cnt_nxt;
         // BOOT is only entered from reset, so the counter cannot wrap.
         if (r_state == ST_BOOT)              r_boot_cnt      <= r_boot_cnt + 4'd1;
         if (w_br_accept)                     r_pc_br         <= io_bus.br_target;
         if (w_stall_cnt_nxt == STALL_MAX)    r_stall_timeout <= 1'b1;
      end
   end

   assign io_bus.pc_write      = w_pc_write;
   assign io_bus.pc_src        = w_pc_src;
   assign io_bus.ifid_write    = w_ifid_write;
   assign io_bus.ifid_flush    = w_ifid_flush;
   assign io_bus.pc_br         = r_pc_br;
   assign io_bus.fetch_state   = r_state;
   assign io_bus.stall_timeout = r_stall_timeout;

`ifdef FETCH_CTRL_PERF_CNT_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_stall;
   logic [31:0] r_perf_redirect;

   // Saturating event counters: they stick at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf_fetch    <= '0;
         r_perf_stall    <= '0;
         r_perf_redirect <= '0;
      end else begin
         if (w_pc_write && (r_perf_fetch != '1))
            r_perf_fetch <= r_perf_fetch + 32'd1;
         if (w_run_stall && (r_perf_stall != '1))
            r_perf_stall <= r_perf_stall + 32'd1;
         if ((r_state == ST_REDIRECT) && (r_perf_redirect != '1))
            r_perf_redirect <= r_perf_redirect + 32'd1;
      end
   end

   assign io_bus.perf_fetch    = r_perf_fetch;
   assign io_bus.perf_stall    = r_perf_stall;
   assign io_bus.perf_redirect = r_perf_redirect;
`else
   assign io_bus.perf_fetch    = '0;
   assign io_bus.perf_stall    = '0;
   assign io_bus.perf_redirect = '0;
`endif

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter BOOT_CYCLES, default 2, number of cycles the PC is held after reset release (range 1..15).
REQ-002 Parameter STALL_LIMIT, default 255, number of consecutive stalled cycles that raises stall_timeout (range 1..65535).
REQ-003 The module SHALL have exactly one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 stall_req  in  1  load-use hazard request to hold PC and IF/ID this cycle.
REQ-006 br_taken  in  1  resolved taken branch; br_target valid this cycle.
REQ-007 br_target  in  64  branch target address.
REQ-008 halt_req  in  1  request to stop fetching.
REQ-009 resume  in  1  leave HALT.
REQ-010 pc_write  out  1  PC register enable.
REQ-011 pc_src  out  1  PC mux select: 0 = PC+4, 1 = pc_br.
REQ-012 pc_br  out  64  registered redirect target.
REQ-013 ifid_write  out  1  IF/ID register enable.
REQ-014 ifid_flush  out  1  IF/ID bubble insert.
REQ-015 fetch_state  out  2  BOOT=0, RUN=1, REDIRECT=2, HALT=3.
REQ-016 stall_timeout  out  1  sticky watchdog flag.
REQ-017 perf_fetch, perf_stall, perf_redirect  out  32 each  performance counters.

Function
REQ-018 States SHALL be BOOT, RUN, REDIRECT, HALT; priority of events SHALL be br_taken > halt_req > stall_req.
REQ-019 BOOT: pc_write=0, ifid_write=0, ifid_flush=1; boot counter increments each cycle; after BOOT_CYCLES cycles go to RUN.
REQ-020 BOOT: br_taken, halt_req and stall_req SHALL be ignored.
REQ-021 RUN: pc_src=0, pc_write=ifid_write=!stall_req (same-cycle, combinational from stall_req), ifid_flush=0.
REQ-022 RUN with br_taken: latch br_target into pc_br at the edge and go to REDIRECT; stall_req in that cycle still gates pc_write.
REQ-023 RUN with halt_req and no br_taken: go to HALT.
REQ-024 REDIRECT (one cycle): pc_src=1, pc_write=1, ifid_write=1, ifid_flush=1, regardless of stall_req.
REQ-025 REDIRECT exit: br_taken -> relatch pc_br and stay REDIRECT; else halt_req -> HALT; else RUN.
REQ-026 HALT: pc_write=0, ifid_write=0, ifid_flush=0; br_taken and stall_req ignored; resume -> RUN next cycle; halt_req and resume both high -> stay HALT.
REQ-027 Stall counter (16-bit) SHALL increment each RUN cycle with stall_req=1, clear on any other cycle, and saturate at STALL_LIMIT.
REQ-028 stall_timeout SHALL set on the edge where the stall counter reaches STALL_LIMIT and stay set until reset.
REQ-029 pc_br SHALL change only when br_taken is accepted (RUN or REDIRECT).

Reset
REQ-030 While rst=0: state=BOOT, boot counter=0, pc_br=0, stall counter=0, stall_timeout=0, perf counters=0; asynchronous to clk.
REQ-031 Reset asserted mid-REDIRECT or mid-HALT SHALL abandon the operation; after release BOOT_CYCLES full cycles of BOOT are repeated.

Configuration
REQ-032 Macro FETCH_CTRL_PERF_CNT_EN defined: perf_fetch counts cycles with pc_write=1, perf_stall counts RUN cycles with stall_req=1, perf_redirect counts REDIRECT cycles; all 32-bit, saturating at 0xFFFFFFFF.
REQ-033 Macro not defined: counters not built, perf outputs tied to 0; all other behaviour identical.

Verification
REQ-034 Release rst, no requests -> fetch_state=0 and pc_write=0 for 2 cycles, then fetch_state=1, pc_write=1 every cycle.
REQ-035 RUN, stall_req high 3 cycles -> pc_write=ifid_write=0 in exactly those 3 cycles; stall counter 3 then 0.
REQ-036 RUN, br_taken with br_target=0x400 one cycle -> next cycle fetch_state=2, pc_src=1, pc_br=0x400, ifid_flush=1; following cycle RUN.
REQ-037 REDIRECT with br_taken (0x800) and stall_req -> stays REDIRECT, pc_br=0x800, pc_write=1; halt_req with br_taken in RUN -> REDIRECT then HALT.
REQ-038 STALL_LIMIT=4, stall_req held 6 cycles -> stall_timeout rises after 4th stalled cycle, stays 1 after stall_req drops.
REQ-039 Macro defined, 10 RUN cycles incl. 2 stalls and 1 redirect -> perf_stall=2, perf_redirect=1; reset mid-HALT -> BOOT, counters 0.
